// File: rtl/alu_issue_pkg.sv
// Shared op codes, ALU control encodings and issue-FSM states for alu_issue.
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDW = 4'd4;
    localparam logic [3:0] OP_SUBW = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_BLT  = 4'd10;
    localparam logic [3:0] OP_BGE  = 4'd11;
    localparam logic [3:0] OP_BLTU = 4'd12;
    localparam logic [3:0] OP_BGEU = 4'd13;

    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_dec.sv
// Combinational op decode: ALUCtrl selection and final result/branch/illegal derivation
// from the ALU output and flags. Zero latency, no handshake.
module alu_op_dec
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_alu_out,
    input  logic            i_alu_carry,
    input  logic            i_alu_zero,
    input  logic            i_alu_overflow,
    output logic [3:0]      o_alu_ctrl,
    output logic [XLEN-1:0] o_result,
    output logic            o_taken,
    output logic            o_illegal
);

    logic w_lt;
    logic w_ltu;
    logic w_eq;

    // Carry set on a subtract means no borrow, i.e. A >= B unsigned.
    assign w_ltu = ~i_alu_carry;
    assign w_lt  = i_alu_out[XLEN-1] ^ i_alu_overflow;
    assign w_eq  = i_alu_zero;

    always_comb begin
        o_alu_ctrl = CTRL_ADD;
        o_result   = '0;
        o_taken    = 1'b0;
        o_illegal  = 1'b0;
        case (i_op)
            OP_ADD:  o_result = i_alu_out;
            OP_SUB:  begin o_alu_ctrl = CTRL_SUB; o_result = i_alu_out; end
            OP_AND:  begin o_alu_ctrl = CTRL_AND; o_result = i_alu_out; end
            OP_OR:   begin o_alu_ctrl = CTRL_OR;  o_result = i_alu_out; end
            OP_ADDW: o_result = {{(XLEN-32){i_alu_out[31]}}, i_alu_out[31:0]};
            OP_SUBW: begin
                o_alu_ctrl = CTRL_SUB;
                o_result   = {{(XLEN-32){i_alu_out[31]}}, i_alu_out[31:0]};
            end
            OP_SLT:  begin o_alu_ctrl = CTRL_SUB; o_result = {{(XLEN-1){1'b0}}, w_lt};  end
            OP_SLTU: begin o_alu_ctrl = CTRL_SUB; o_result = {{(XLEN-1){1'b0}}, w_ltu}; end
            OP_BEQ:  begin o_alu_ctrl = CTRL_SUB; o_taken = w_eq;   end
            OP_BNE:  begin o_alu_ctrl = CTRL_SUB; o_taken = ~w_eq;  end
            OP_BLT:  begin o_alu_ctrl = CTRL_SUB; o_taken = w_lt;   end
            OP_BGE:  begin o_alu_ctrl = CTRL_SUB; o_taken = ~w_lt;  end
            OP_BLTU: begin o_alu_ctrl = CTRL_SUB; o_taken = w_ltu;  end
            OP_BGEU: begin o_alu_ctrl = CTRL_SUB; o_taken = ~w_ltu; end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue FSM driving an external combinational ALU; result valid two cycles after accept,
// results held stable while out_ready is low, and a new request can be taken on the retiring cycle.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_carry,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_taken,
    output logic            out_illegal
);

    state_e          r_state;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_taken;
    logic            r_illegal;

    logic [XLEN-1:0] w_dec_result;
    logic            w_dec_taken;
    logic            w_dec_illegal;
    logic            w_accept;

    alu_op_dec #(.XLEN(XLEN)) u_dec (
        .i_op           (r_op),
        .i_alu_out      (alu_out),
        .i_alu_carry    (alu_carry),
        .i_alu_zero     (alu_zero),
        .i_alu_overflow (alu_overflow),
        .o_alu_ctrl     (alu_ctrl),
        .o_result       (w_dec_result),
        .o_taken        (w_dec_taken),
        .o_illegal      (w_dec_illegal)
    );

    // Ready depends only on state and out_ready so decode never sees an in_valid->in_ready loop.
    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_taken   = r_taken;
    assign out_illegal = r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_taken     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= in_op;
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result    <= w_dec_result;
                    r_taken     <= w_dec_taken;
                    r_illegal   <= w_dec_illegal;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_op    <= in_op;
                            r_a     <= in_a;
                            r_b     <= in_b;
                            r_state <= ST_EXEC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural ALU and an arithmetic reference model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [63:0] in_a = 64'd0;
    logic [63:0] in_b = 64'd0;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic        out_taken;
    logic        out_illegal;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_taken    (out_taken),
        .out_illegal  (out_illegal)
    );

    // Behavioural 64-bit ALU, as the parent would instantiate it.
    logic [64:0] alu_sum;
    always_comb begin
        alu_sum      = 65'd0;
        alu_out      = 64'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'b0010: begin
                alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out      = alu_sum[63:0];
                alu_carry    = alu_sum[64];
                alu_overflow = (alu_a[63] == alu_b[63]) && (alu_out[63] != alu_a[63]);
            end
            4'b0110: begin
                alu_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
                alu_out      = alu_sum[63:0];
                alu_carry    = alu_sum[64];
                alu_overflow = (alu_a[63] != alu_b[63]) && (alu_out[63] != alu_a[63]);
            end
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            default: alu_out = 64'd0;
        endcase
        alu_zero = (alu_out == 64'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Reference: what each op means architecturally, straight from operand arithmetic.
    task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic t, output logic il, output logic [3:0] ctrl);
        logic [63:0] s;
        logic [63:0] d;
        logic slt;
        logic sltu;
        s    = a + b;
        d    = a - b;
        slt  = ($signed(a) < $signed(b));
        sltu = (a < b);
        r    = 64'd0;
        t    = 1'b0;
        il   = 1'b0;
        ctrl = 4'b0110;
        case (op)
            4'd0:  begin r = s; ctrl = 4'b0010; end
            4'd1:  r = d;
            4'd2:  begin r = a & b; ctrl = 4'b0000; end
            4'd3:  begin r = a | b; ctrl = 4'b0001; end
            4'd4:  begin r = {{32{s[31]}}, s[31:0]}; ctrl = 4'b0010; end
            4'd5:  r = {{32{d[31]}}, d[31:0]};
            4'd6:  r = {63'd0, slt};
            4'd7:  r = {63'd0, sltu};
            4'd8:  t = (a == b);
            4'd9:  t = (a != b);
            4'd10: t = slt;
            4'd11: t = ~slt;
            4'd12: t = sltu;
            4'd13: t = ~sltu;
            default: begin il = 1'b1; ctrl = 4'b0010; end
        endcase
    endtask

    // One complete op with out_ready high: accept, EXEC, DONE, back to IDLE.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er;
        logic        et;
        logic        ei;
        logic [3:0]  ec;
        model(op, a, b, er, et, ei, ec);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        #1 check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        check("exec_out_valid", {63'd0, out_valid}, 64'd0);
        check("exec_in_ready",  {63'd0, in_ready},  64'd0);
        check("exec_alu_ctrl",  {60'd0, alu_ctrl},  {60'd0, ec});
        check("exec_alu_a",     alu_a, a);
        check("exec_alu_b",     alu_b, b);
        @(posedge clk); #1;
        check("done_out_valid", {63'd0, out_valid},   64'd1);
        check("done_result",    out_result, er);
        check("done_taken",     {63'd0, out_taken},   {63'd0, et});
        check("done_illegal",   {63'd0, out_illegal}, {63'd0, ei});
        @(posedge clk); #1;
        check("retire_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",   {63'd0, out_valid},   64'd0);
        check("rst_in_ready",    {63'd0, in_ready},    64'd1);
        check("rst_out_result",  out_result,           64'd0);
        check("rst_out_taken",   {63'd0, out_taken},   64'd0);
        check("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        check("rst_alu_a",       alu_a,                64'd0);
        check("rst_alu_b",       alu_b,                64'd0);
        check("rst_alu_ctrl",    {60'd0, alu_ctrl},    64'd2);
        rst = 1'b0;

        // Directed corner cases.
        run_op(4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_op(4'd5,  64'd0, 64'd1);
        run_op(4'd4,  64'h0000_0000_7FFF_FFFF, 64'd1);
        run_op(4'd6,  64'h8000_0000_0000_0000, 64'd1);
        run_op(4'd7,  64'h8000_0000_0000_0000, 64'd1);
        run_op(4'd10, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(4'd13, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(4'd8,  64'h1234, 64'h1234);
        run_op(4'd9,  64'h1234, 64'h1234);
        run_op(4'd15, 64'h55, 64'h22);
        run_op(4'd14, 64'h1, 64'h1);

        // Backpressure: five stalled cycles in DONE, then retire with a same-cycle accept.
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 4'd1;
        in_a      = 64'd100;
        in_b      = 64'd58;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_first_valid",  {63'd0, out_valid}, 64'd1);
        check("bp_first_result", out_result, 64'd42);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = 4'($urandom);
            in_a     = {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            #1 check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            check("bp_out_valid",   {63'd0, out_valid},   64'd1);
            check("bp_out_result",  out_result,           64'd42);
            check("bp_out_taken",   {63'd0, out_taken},   64'd0);
            check("bp_out_illegal", {63'd0, out_illegal}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 4'd3;
        in_a      = 64'hF0;
        in_b      = 64'h0F;
        #1 check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_exec_valid", {63'd0, out_valid}, 64'd0);
        check("bp_next_exec_ctrl",  {60'd0, alu_ctrl},  64'd1);
        @(posedge clk); #1;
        check("bp_next_valid",  {63'd0, out_valid}, 64'd1);
        check("bp_next_result", out_result, 64'hFF);
        @(posedge clk); #1;
        check("bp_next_retire", {63'd0, out_valid}, 64'd0);

        // Reset while the op sits in EXEC: it must vanish.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd1;
        in_a     = 64'd9;
        in_b     = 64'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_exec_ctrl", {60'd0, alu_ctrl}, 64'd6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready",  {63'd0, in_ready},  64'd1);
        check("abort_alu_ctrl",  {60'd0, alu_ctrl},  64'd2);
        check("abort_alu_a",     alu_a,              64'd0);
        check("abort_result",    out_result,         64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_output", {63'd0, out_valid}, 64'd0);
        end

        // Randomized ops, with a bias toward equal and small operands for the compare paths.
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0, 1:    b = a;
                2:       begin a = 64'($urandom_range(0, 7)); b = 64'($urandom_range(0, 7)); end
                3:       b = {~a[63], a[62:0]};
                default: b = {$urandom, $urandom};
            endcase
            run_op(op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
